// File: rtl/store_load_queue_if.sv
// CPU request/response, datamem port and store-buffer status of store_load_queue.
// slave is the queue side; master is the CPU/datamem side.
interface store_load_queue_if #(
  parameter int unsigned CNT_W = 3
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_wen;
  logic [1:0]       mem_width;
  logic [31:0]      mem_rdata;
  logic [CNT_W-1:0] sb_count;
  logic             sb_empty;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_wen, mem_width,
           sb_count, sb_empty
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_wen, mem_width,
           sb_count, sb_empty
  );
endinterface

// File: rtl/store_load_queue.sv
// Memory front end: in-order store buffer draining one store per cycle into datamem,
// loads issued only when the buffer is empty, with registered sign/zero-extended response.
module store_load_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input logic                clk,
  input logic                rst,
  store_load_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;

  logic [31:0] ent_addr  [DEPTH];
  logic [31:0] ent_wdata [DEPTH];
  logic [1:0]  ent_width [DEPTH];

  logic        drain, can_store, store_hs, load_hs;
  logic [1:0]  req_width;
  logic [31:0] load_data;

  // datamem encoding is reversed relative to the CPU size field
  function automatic logic [1:0] size_to_width(input logic [1:0] size);
    case (size)
      2'b00:   return 2'b10;
      2'b01:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    drain     = (count_q != '0);
    can_store = (count_q < CNT_W'(DEPTH));
    store_hs  = bus.req_valid & bus.req_we & can_store;
    load_hs   = bus.req_valid & ~bus.req_we & ~drain;
    req_width = size_to_width(bus.req_size);
    bus.req_ready = bus.req_we ? can_store : ~drain;
    bus.sb_count  = count_q;
    bus.sb_empty  = ~drain;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_rdata = rsp_rdata_q;
  end

  // The drain always owns the memory port; a load only gets it when nothing is buffered.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_width = 2'b00;
    if (drain) begin
      bus.mem_addr  = ent_addr[head_q];
      bus.mem_wdata = ent_wdata[head_q];
      bus.mem_wen   = 1'b1;
      bus.mem_width = ent_width[head_q];
    end else if (load_hs) begin
      bus.mem_addr  = bus.req_addr;
      bus.mem_width = req_width;
    end
  end

  always_comb begin
    case (bus.req_size)
      2'b00:   load_data = {{24{~bus.req_unsigned & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      2'b01:   load_data = {{16{~bus.req_unsigned & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (store_hs) tail_q <= tail_q + PTR_W'(1);
      if (drain)    head_q <= head_q + PTR_W'(1);
      case ({store_hs, drain})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      rsp_valid_q <= load_hs;
      if (load_hs) rsp_rdata_q <= load_data;
    end
  end

  // Entry storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (store_hs) begin
      ent_addr[tail_q]  <= bus.req_addr;
      ent_wdata[tail_q] <= bus.req_wdata;
      ent_width[tail_q] <= req_width;
    end
  end
endmodule

// File: tb/tb_store_load_queue.sv
// Randomised and directed bench for store_load_queue with a byte-array datamem model
// and a scoreboard of expected memory writes and load responses.
module tb_store_load_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  store_load_queue_if #(.CNT_W(CNT_W)) bus ();

  store_load_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          acc;
  } st_t;

  typedef struct {
    logic [31:0] data;
    int          iss;
  } rs_t;

  st_t st_q[$];
  rs_t rs_q[$];
  logic [7:0] dmem    [256];
  logic [7:0] ref_mem [256];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  bit  load_now = 1'b0;
  bit  mon_en   = 1'b0;

  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] map_w(input logic [1:0] sz);
    case (sz)
      2'd0:    return 2'b10;
      2'd1:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int nbytes_size(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int nbytes_width(input logic [1:0] w);
    return (w == 2'b10) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input bit uns);
    logic [7:0]  b [4];
    logic [7:0]  idx;
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      idx  = a[7:0] + 8'(k);
      b[k] = ref_mem[idx];
    end
    case (sz)
      2'd0: begin
        v = {24'd0, b[0]};
        if (!uns && b[0] >= 8'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = {16'd0, b[1], b[0]};
        if (!uns && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = {b[3], b[2], b[1], b[0]};
    endcase
    return v;
  endfunction

  task automatic ref_write(input st_t s);
    logic [7:0] idx;
    for (int i = 0; i < nbytes_size(s.size); i++) begin
      idx = s.addr[7:0] + 8'(i);
      ref_mem[idx] = s.wdata[8*i +: 8];
    end
  endtask

  // datamem model: combinational read, write on the clock edge
  always_comb begin
    bus.mem_rdata = '0;
    for (int k = 0; k < 4; k++) bus.mem_rdata[8*k +: 8] = dmem[bus.mem_addr[7:0] + 8'(k)];
  end

  always @(posedge clk) begin
    if (!rst && bus.mem_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nbytes_width(bus.mem_width))
          dmem[bus.mem_addr[7:0] + 8'(i)] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

  // One bus cycle: drive at the falling edge, check readiness and handshake 1 ns later.
  task automatic cycle_drive(input bit v, input bit we, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd, input bit use_lit,
                             input logic [31:0] lit, output bit acc);
    bit          exp_rdy;
    logic [31:0] e;
    @(negedge clk);
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    #1;
    load_now = 1'b0;
    check("sb_count", 32'(bus.sb_count), 32'(st_q.size()));
    check("sb_empty", 32'(bus.sb_empty), 32'(st_q.size() == 0));
    if (v) begin
      exp_rdy = we ? (st_q.size() < int'(DEPTH)) : (st_q.size() == 0);
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    end
    acc = v && bus.req_ready;
    if (acc && we) st_q.push_back('{a, wd, sz, cyc});
    if (acc && !we) begin
      load_now = 1'b1;
      check("load_mem_addr", bus.mem_addr, a);
      check("load_mem_wen", 32'(bus.mem_wen), 32'd0);
      check("load_mem_wdata", bus.mem_wdata, 32'd0);
      check("load_mem_width", 32'(bus.mem_width), 32'(map_w(sz)));
      e = use_lit ? lit : ref_load(a, sz, uns);
      rs_q.push_back('{e, cyc});
    end
  endtask

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input bit use_lit,
                        input logic [31:0] lit);
    bit acc;
    int n = 0;
    do begin
      cycle_drive(1'b1, we, sz, uns, a, wd, use_lit, lit, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: request @%h not accepted after %0d cycles", a, n);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle_drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, acc);
  endtask

  // Monitor: memory writes and load responses against the scoreboard queues.
  initial begin
    st_t s;
    rs_t r;
    bit  exp_wen;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !rst) begin
        exp_wen = (st_q.size() > 0) && (st_q[0].acc < cyc);
        check("mem_wen", 32'(bus.mem_wen), 32'(exp_wen));
        if (bus.mem_wen && exp_wen) begin
          s = st_q.pop_front();
          check("drain_addr", bus.mem_addr, s.addr);
          check("drain_wdata", bus.mem_wdata, s.wdata);
          check("drain_width", 32'(bus.mem_width), 32'(map_w(s.size)));
          ref_write(s);
        end else if (!bus.mem_wen && !load_now) begin
          check("idle_addr", bus.mem_addr, 32'd0);
          check("idle_wdata", bus.mem_wdata, 32'd0);
          check("idle_width", 32'(bus.mem_width), 32'd0);
        end
        if (bus.rsp_valid) begin
          if (rs_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid=1 data %h, none expected", bus.rsp_rdata);
          end else begin
            r = rs_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, r.data);
            check("rsp_latency", 32'(cyc - r.iss), 32'd1);
          end
        end else if (rs_q.size() > 0 && rs_q[0].iss < cyc) begin
          r = rs_q.pop_front();
          checks++;
          errors++;
          $display("FAIL rsp_missing: rsp_valid=0, expected data %h", r.data);
        end
      end
    end
  end

  initial begin
    bit          have, acc, r_we, r_uns;
    logic [1:0]  r_sz;
    logic [31:0] r_a, r_wd, v;
    for (int i = 0; i < 256; i++) begin
      v          = $urandom;
      dmem[i]    = v[7:0];
      ref_mem[i] = v[7:0];
    end
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    #1;
    check("reset_sb_count", 32'(bus.sb_count), 32'd0);
    check("reset_sb_empty", 32'(bus.sb_empty), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_mem_wen", 32'(bus.mem_wen), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // store then load of the same word
    do_req(1'b1, 2'd2, 1'b0, 32'h10000, 32'hDEADBEEF, 1'b0, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10000, 32'd0, 1'b1, 32'hDEADBEEF);
    idle(2);

    // sign/zero extension of byte and half loads
    do_req(1'b1, 2'd2, 1'b0, 32'h10020, 32'h000000F0, 1'b0, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10024, 32'h00008001, 1'b0, 32'd0);
    do_req(1'b0, 2'd0, 1'b0, 32'h10020, 32'd0, 1'b1, 32'hFFFFFFF0);
    do_req(1'b0, 2'd0, 1'b1, 32'h10020, 32'd0, 1'b1, 32'h000000F0);
    do_req(1'b0, 2'd1, 1'b0, 32'h10024, 32'd0, 1'b1, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h10024, 32'd0, 1'b1, 32'h00008001);
    idle(2);

    // five back-to-back stores, drained in order
    for (int i = 0; i < 5; i++)
      do_req(1'b1, 2'd2, 1'b0, 32'h10000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0, 32'd0);

    // load presented while stores are still buffered
    do_req(1'b1, 2'd2, 1'b0, 32'h10040, 32'h11223344, 1'b0, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10044, 32'h55667788, 1'b0, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10044, 32'd0, 1'b1, 32'h55667788);

    // three consecutive word loads on an empty buffer
    do_req(1'b0, 2'd2, 1'b0, 32'h10000, 32'd0, 1'b1, 32'hC0DE0000);
    do_req(1'b0, 2'd2, 1'b0, 32'h10004, 32'd0, 1'b1, 32'hC0DE0001);
    do_req(1'b0, 2'd2, 1'b0, 32'h10008, 32'd0, 1'b1, 32'hC0DE0002);
    idle(2);

    // random mix; an unaccepted request is held until it is taken
    have = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        have  = 1'b1;
        r_we  = 1'($urandom_range(0, 1));
        r_sz  = 2'($urandom_range(0, 3));
        r_uns = 1'($urandom_range(0, 1));
        r_a   = 32'h10000 + 32'($urandom_range(0, 255));
        r_wd  = $urandom;
      end
      cycle_drive(have, r_we, r_sz, r_uns, r_a, r_wd, 1'b0, 32'd0, acc);
      if (acc) have = 1'b0;
    end
    idle(3);

    // asynchronous reset while a drain is in flight; buffered stores are dropped
    do_req(1'b1, 2'd2, 1'b0, 32'h10080, 32'hAAAA0001, 1'b0, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10084, 32'hAAAA0002, 1'b0, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10088, 32'hAAAA0003, 1'b0, 32'd0);
    #2;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    check("midreset_sb_count", 32'(bus.sb_count), 32'd0);
    check("midreset_mem_wen", 32'(bus.mem_wen), 32'd0);
    check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    st_q.delete();
    rs_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(6);

    check("end_store_queue_empty", 32'(st_q.size()), 32'd0);
    check("end_rsp_queue_empty", 32'(rs_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
